// File: rtl/buff_pkg.sv
// Shared definitions for the buffer blocks.
// Holds the default depth/width and the helpers that size pointers and
// occupancy counters. Depths need not be powers of two.
package buff_pkg;

    localparam int DEF_NUMELEM = 8;
    localparam int DEF_BITDATA = 8;

    // Pointer width for a buffer of 'depth' entries (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy counter width: must hold the value 'depth' itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/buff_mem.sv
// Storage array for the buffer: DEPTH x WIDTH, one synchronous write port
// and one asynchronous (combinational) read port. No reset; contents persist
// across rst and flush.
//   clk   - write clock
//   we    - write enable
//   waddr - write address, wdata - write data
//   raddr - read address,  rdata - read data (combinational)
module buff_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/flex_buff.sv
// Synchronous FIFO of arbitrary depth (2..256, not only powers of two).
// Pointers wrap explicitly at NUMELEM-1. Read data is combinational from the
// head entry. Overflow/underflow are sticky until flush or rst.
//   clk, rst (async, active-high), flush (sync clear)
//   push, pu_din, pu_rdy       - write side
//   pop, po_dout, po_vld       - read side
//   cnt                        - occupancy
//   full, empty, afull, aempty - status from registered cnt
//   ovf, udf                   - sticky error flags
module flex_buff
    import buff_pkg::*;
#(
    parameter int NUMELEM   = DEF_NUMELEM,
    parameter int BITDATA   = DEF_BITDATA,
    parameter int AFULL_TH  = NUMELEM - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            push,
    input  logic [BITDATA-1:0]              pu_din,
    output logic                            pu_rdy,
    input  logic                            pop,
    output logic [BITDATA-1:0]              po_dout,
    output logic                            po_vld,
    output logic [cnt_width(NUMELEM)-1:0]   cnt,
    output logic                            full,
    output logic                            empty,
    output logic                            afull,
    output logic                            aempty,
    output logic                            ovf,
    output logic                            udf
);

    localparam int PW = ptr_width(NUMELEM);
    localparam int CW = cnt_width(NUMELEM);

    localparam logic [CW-1:0] FULL_C   = CW'(NUMELEM);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
    localparam logic [PW-1:0] LAST_P   = PW'(NUMELEM - 1);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign empty  = (cnt == '0);
    assign full   = (cnt == FULL_C);
    assign afull  = (cnt >= AFULL_C);
    assign aempty = (cnt <= AEMPTY_C);
    assign po_vld = ~empty;

    // A pop accepted in the same cycle frees a slot, so a full buffer can
    // still take a push. No bypass when empty: the pop is simply rejected.
    assign pu_rdy  = ~full | (pop & ~empty);
    assign do_pop  = pop & ~empty;
    assign do_push = push & pu_rdy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            if (do_push) begin
                tail <= ptr_inc(tail);
            end
            if (do_pop) begin
                head <= ptr_inc(head);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (push & ~pu_rdy) begin
                ovf <= 1'b1;
            end
            if (pop & empty) begin
                udf <= 1'b1;
            end
        end
    end

    buff_mem #(
        .DEPTH (NUMELEM),
        .WIDTH (BITDATA),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (do_push & ~flush),
        .waddr (tail),
        .wdata (pu_din),
        .raddr (head),
        .rdata (po_dout)
    );

endmodule
